// File: rtl/sdpram_sync_fifo_ctrl.sv
// sdpram_sync_fifo_ctrl
//
// Single-clock FIFO controller in front of one simple-dual-port RAM. It owns
// the write/read pointers, the occupancy count and the status flags, and
// drives the RAM's write port and read address. The RAM's optional output
// register is hidden: popped data always appears exactly one cycle after the
// accepted pop, with rd_valid marking it.
//
// Ports:
//   clk           controller clock; also the RAM's wr_clk and rd_clk
//   rst           synchronous active-high reset (also the RAM's sync rst)
//   flush         synchronous clear of pointers/count, RAM contents kept
//   wr_en/wr_data push request and data
//   rd_en         pop request
//   rd_data       popped word, valid while rd_valid=1
//   rd_valid      one-cycle pulse, one cycle after an accepted pop
//   full, empty, almost_full, almost_empty   registered status flags
//   count         occupancy, 0..DEPTH
//   wr_err        one-cycle pulse: push rejected because full
//   rd_err        one-cycle pulse: pop rejected because empty
//   ram_wr_en/ram_wr_addr/ram_wr_data        RAM write port
//   ram_rd_addr/ram_rd_data                  RAM read port
//
// RAM_OUT_REG must match the RAM: 0 = combinational read, 1 = registered read.

module sdpram_sync_fifo_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int RAM_OUT_REG = 0,
  parameter int AF_LEVEL    = (2 ** ADDR_WIDTH) - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ZRO = '0;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [ADDR_WIDTH:0]   count_next;

  // Acceptance uses the registered flags, so a push and a pop in the same
  // cycle never see each other's effect. This is also what keeps the RAM
  // free of same-address write/read collisions.
  always_comb begin
    push_ok    = wr_en & ~full;
    pop_ok     = rd_en & ~empty;
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  assign ram_wr_en   = push_ok;
  assign ram_wr_addr = wr_ptr;
  assign ram_wr_data = wr_data;
  assign ram_rd_addr = rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // flush only drops the FIFO state; a request seen alongside it is
      // discarded without raising an error pulse.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      rd_valid     <= 1'b0;
      wr_err       <= 1'b0;
      rd_err       <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count        <= count_next;
      full         <= (count_next == DEPTH_C);
      empty        <= (count_next == CNT_ZRO);
      almost_full  <= (count_next >= AF_C);
      almost_empty <= (count_next <= AE_C);
      rd_valid     <= pop_ok;
      wr_err       <= wr_en & full;
      rd_err       <= rd_en & empty;
    end
  end

  generate
    if (RAM_OUT_REG == 0) begin : g_rd_reg
      // Combinational RAM read: capture the word at the old rd_ptr here so
      // it lines up with rd_valid. The word holds between pops and across
      // flush; only reset clears it.
      logic [DATA_WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data_q <= '0;
        end else if (!flush && pop_ok) begin
          rd_data_q <= ram_rd_data;
        end
      end

      assign rd_data = rd_data_q;
    end else begin : g_rd_pass
      // The RAM's own output register already samples mem[rd_ptr] at the
      // pop edge, so its output is the popped word during rd_valid.
      assign rd_data = ram_rd_data;
    end
  endgenerate

  a_levels : assert property (@(posedge clk) (AF_LEVEL <= DEPTH) && (AE_LEVEL < DEPTH))
    else $error("sdpram_sync_fifo_ctrl: AF_LEVEL must be <= DEPTH and AE_LEVEL < DEPTH");

endmodule

// File: tb/tb_sdpram_sync_fifo_ctrl.sv
// Bench for sdpram_sync_fifo_ctrl. Two instances share one stimulus stream:
// u_dut0 in front of a combinational-read RAM model, u_dut1 in front of a
// registered-read RAM model. A directed vector table is applied to both;
// flags are derived from the expected count with the fixed thresholds
// (DEPTH=16, almost_full at >=14, almost_empty at <=2).

module tb_sdpram_sync_fifo_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] wr_data = '0;

  logic [15:0] rd_data_s   [2];
  logic [1:0]  rd_valid_s, full_s, empty_s, af_s, ae_s, wr_err_s, rd_err_s, ram_wr_en_s;
  logic [4:0]  count_s     [2];
  logic [3:0]  ram_wr_addr_s [2];
  logic [3:0]  ram_rd_addr_s [2];
  logic [15:0] ram_wr_data_s [2];
  logic [15:0] ram_rd_data_s [2];

  logic [15:0] mem0 [16];
  logic [15:0] mem1 [16];
  logic [15:0] ram1_q;

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = '0;
      mem1[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_wr_en_s[0]) mem0[ram_wr_addr_s[0]] <= ram_wr_data_s[0];
  end
  assign ram_rd_data_s[0] = mem0[ram_rd_addr_s[0]];

  always @(posedge clk) begin
    if (ram_wr_en_s[1]) mem1[ram_wr_addr_s[1]] <= ram_wr_data_s[1];
    if (rst) ram1_q <= '0;
    else     ram1_q <= mem1[ram_rd_addr_s[1]];
  end
  assign ram_rd_data_s[1] = ram1_q;

  sdpram_sync_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RAM_OUT_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_s[0]), .rd_valid(rd_valid_s[0]), .full(full_s[0]), .empty(empty_s[0]),
    .almost_full(af_s[0]), .almost_empty(ae_s[0]), .count(count_s[0]),
    .wr_err(wr_err_s[0]), .rd_err(rd_err_s[0]), .ram_wr_en(ram_wr_en_s[0]),
    .ram_wr_addr(ram_wr_addr_s[0]), .ram_wr_data(ram_wr_data_s[0]),
    .ram_rd_addr(ram_rd_addr_s[0]), .ram_rd_data(ram_rd_data_s[0])
  );

  sdpram_sync_fifo_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RAM_OUT_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_s[1]), .rd_valid(rd_valid_s[1]), .full(full_s[1]), .empty(empty_s[1]),
    .almost_full(af_s[1]), .almost_empty(ae_s[1]), .count(count_s[1]),
    .wr_err(wr_err_s[1]), .rd_err(rd_err_s[1]), .ram_wr_en(ram_wr_en_s[1]),
    .ram_wr_addr(ram_wr_addr_s[1]), .ram_wr_data(ram_wr_data_s[1]),
    .ram_rd_addr(ram_rd_addr_s[1]), .ram_rd_data(ram_rd_data_s[1])
  );

  typedef struct {
    bit          rst, flush, we, re;
    logic [15:0] wd;
    bit          chk_pre;   // check the combinational RAM-side outputs before the edge
    bit          wen;
    logic [3:0]  wa, ra;
    logic [4:0]  cnt;
    bit          emp, ful, af, ae;
    bit          rv;
    logic [15:0] rd;
    bit          chk_rd;
    bit          werr, rerr;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic void add(bit r, bit f, bit we, bit re, logic [15:0] wd,
                              bit cp, bit wen, int wa, int ra,
                              int cnt, bit rv, logic [15:0] rd, bit werr, bit rerr);
    vec_t v;
    v.rst = r; v.flush = f; v.we = we; v.re = re; v.wd = wd;
    v.chk_pre = cp; v.wen = wen; v.wa = 4'(wa % 16); v.ra = 4'(ra % 16);
    v.cnt = 5'(cnt);
    v.emp = (cnt == 0); v.ful = (cnt == 16); v.af = (cnt >= 14); v.ae = (cnt <= 2);
    v.rv = rv; v.rd = rd; v.chk_rd = rv | r;
    v.werr = werr; v.rerr = rerr;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset then idle
    add(1,0,0,0,16'h0, 0,0,0,0, 0, 0,16'h0, 0,0);
    add(0,0,0,0,16'h0, 1,0,0,0, 0, 0,16'h0, 0,0);
    add(0,0,0,0,16'h0, 1,0,0,0, 0, 0,16'h0, 0,0);
    // fill 16 words
    for (int i = 0; i < 16; i++)
      add(0,0,1,0,16'(i), 1,1,i,0, i+1, 0,16'h0, 0,0);
    // 17th push rejected; wr_ptr has wrapped to 0
    add(0,0,1,0,16'h00FF, 1,0,0,0, 16, 0,16'h0, 1,0);
    // drain 16 words in order
    for (int j = 0; j < 16; j++)
      add(0,0,0,1,16'h0, 1,0,0,j, 15-j, 1,16'(j), 0,0);
    // pop on empty, then the rd_err pulse ends
    add(0,0,0,1,16'h0, 1,0,0,0, 0, 0,16'h0, 0,1);
    add(0,0,0,0,16'h0, 1,0,0,0, 0, 0,16'h0, 0,0);
    // push then pop A5A5
    add(0,0,1,0,16'hA5A5, 1,1,0,0, 1, 0,16'h0, 0,0);
    add(0,0,0,1,16'h0,    1,0,1,0, 0, 1,16'hA5A5, 0,0);
    // build count=8 (wr_ptr 1..8, rd_ptr 1)
    for (int k = 0; k < 8; k++)
      add(0,0,1,0,16'(16'h100 + k), 1,1,1+k,1, k+1, 0,16'h0, 0,0);
    // 20 cycles of push+pop across the pointer wrap
    for (int c = 0; c < 20; c++)
      add(0,0,1,1,16'(16'h200 + c), 1,1,9+c,1+c, 8, 1,
          (c < 8) ? 16'(16'h100 + c) : 16'(16'h200 + c - 8), 0,0);
    // fill to 16 (wr_ptr 13..20 mod 16, rd_ptr 5)
    for (int k = 0; k < 8; k++)
      add(0,0,1,0,16'(16'h300 + k), 1,1,13+k,5, 9+k, 0,16'h0, 0,0);
    // push+pop at full: pop accepted, push rejected
    add(0,0,1,1,16'h03FF, 1,0,5,5, 15, 1,16'h020C, 1,0);
    // drain the remaining 15 words
    for (int j = 0; j < 15; j++)
      add(0,0,0,1,16'h0, 1,0,5,6+j, 14-j, 1,
          (j < 7) ? 16'(16'h20D + j) : 16'(16'h300 + j - 7), 0,0);
    // push+pop at empty: push accepted, pop rejected
    add(0,0,1,1,16'h4444, 1,1,5,5, 1, 0,16'h0, 0,1);
    add(0,0,0,1,16'h0,    1,0,6,5, 0, 1,16'h4444, 0,0);
    // build count=10 then flush with push+pop asserted
    for (int k = 0; k < 10; k++)
      add(0,0,1,0,16'(16'h500 + k), 1,1,6+k,6, k+1, 0,16'h0, 0,0);
    add(0,1,1,1,16'hDEAD, 1,1,0,6, 0, 0,16'h0, 0,0);
    add(0,0,1,0,16'h6666, 1,1,0,0, 1, 0,16'h0, 0,0);
    add(0,0,0,1,16'h0,    1,0,1,0, 0, 1,16'h6666, 0,0);
    // build count=5 (7 pushes, 2 pops), then reset mid-drain
    for (int k = 0; k < 7; k++)
      add(0,0,1,0,16'(16'h700 + k), 1,1,1+k,1, k+1, 0,16'h0, 0,0);
    add(0,0,0,1,16'h0, 1,0,8,1, 6, 1,16'h0700, 0,0);
    add(0,0,0,1,16'h0, 1,0,8,2, 5, 1,16'h0701, 0,0);
    add(1,0,0,1,16'h0, 0,0,0,0, 0, 0,16'h0, 0,0);
    add(0,0,1,0,16'h1234, 1,1,0,0, 1, 0,16'h0, 0,0);
    add(0,0,0,1,16'h0,    1,0,1,0, 0, 1,16'h1234, 0,0);

    foreach (vq[i]) begin
      rst = vq[i].rst; flush = vq[i].flush;
      wr_en = vq[i].we; rd_en = vq[i].re; wr_data = vq[i].wd;
      #1;
      if (vq[i].chk_pre) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("ram_wr_en%0d", d),   i, 32'(ram_wr_en_s[d]),   32'(vq[i].wen));
          chk($sformatf("ram_wr_addr%0d", d), i, 32'(ram_wr_addr_s[d]), 32'(vq[i].wa));
          chk($sformatf("ram_rd_addr%0d", d), i, 32'(ram_rd_addr_s[d]), 32'(vq[i].ra));
        end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("count%0d", d),        i, 32'(count_s[d]),    32'(vq[i].cnt));
        chk($sformatf("empty%0d", d),        i, 32'(empty_s[d]),    32'(vq[i].emp));
        chk($sformatf("full%0d", d),         i, 32'(full_s[d]),     32'(vq[i].ful));
        chk($sformatf("almost_full%0d", d),  i, 32'(af_s[d]),       32'(vq[i].af));
        chk($sformatf("almost_empty%0d", d), i, 32'(ae_s[d]),       32'(vq[i].ae));
        chk($sformatf("rd_valid%0d", d),     i, 32'(rd_valid_s[d]), 32'(vq[i].rv));
        chk($sformatf("wr_err%0d", d),       i, 32'(wr_err_s[d]),   32'(vq[i].werr));
        chk($sformatf("rd_err%0d", d),       i, 32'(rd_err_s[d]),   32'(vq[i].rerr));
        if (vq[i].chk_rd)
          chk($sformatf("rd_data%0d", d),    i, 32'(rd_data_s[d]),  32'(vq[i].rd));
      end
    end

    // idle after the last pop: rd_valid drops, combinational-read variant
    // keeps the popped word on rd_data
    rst = 0; flush = 0; wr_en = 0; rd_en = 0; wr_data = '0;
    @(posedge clk);
    #1;
    chk("hold_rd_valid0", 900, 32'(rd_valid_s[0]), 32'd0);
    chk("hold_rd_valid1", 900, 32'(rd_valid_s[1]), 32'd0);
    chk("hold_rd_data0",  900, 32'(rd_data_s[0]),  32'h1234);

    // rst wins over flush and push: reset values and cleared rd_data
    rst = 1; flush = 1; wr_en = 1; wr_data = 16'hBEEF;
    @(posedge clk);
    #1;
    rst = 0; flush = 0; wr_en = 0;
    chk("prio_count0",   901, 32'(count_s[0]),   32'd0);
    chk("prio_empty1",   901, 32'(empty_s[1]),   32'd1);
    chk("prio_rd_data0", 901, 32'(rd_data_s[0]), 32'd0);
    chk("prio_rd_data1", 901, 32'(rd_data_s[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

endmodule
